// File: rtl/display_scan_controller_if.sv
// Handshake and display bus of the four-digit multiplexed seven-segment scan controller.
interface display_scan_controller_if;
  logic [15:0] data_in;
  logic        load;
  logic        ready;
  logic        lzb;
  logic        disp_en;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        frame_done;
  logic        overrun;

  modport master (
    output data_in, load, lzb, disp_en,
    input  ready, an, sseg, frame_done, overrun
  );

  modport slave (
    input  data_in, load, lzb, disp_en,
    output ready, an, sseg, frame_done, overrun
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with a shadow register that is
// swapped into the displayed register only at frame boundaries (tear-free).
module display_scan_controller #(
  parameter int DIGIT_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  display_scan_controller_if.slave   bus
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state, nxt_state;
  logic [1:0]    idx, nxt_idx;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [15:0]   displayed, shadow, nxt_disp;
  logic          pending, nxt_pending;
  logic          slot_end, boundary, accept, visible, lz_blank;
  logic [3:0]    nibble;
  logic [3:0]    nxt_an;
  logic [6:0]    nxt_sseg;

  function automatic logic [6:0] hex_code(input logic [3:0] v);
    case (v)
      4'h0: hex_code = 7'h40;
      4'h1: hex_code = 7'h79;
      4'h2: hex_code = 7'h24;
      4'h3: hex_code = 7'h30;
      4'h4: hex_code = 7'h19;
      4'h5: hex_code = 7'h12;
      4'h6: hex_code = 7'h02;
      4'h7: hex_code = 7'h78;
      4'h8: hex_code = 7'h00;
      4'h9: hex_code = 7'h10;
      4'hA: hex_code = 7'h08;
      4'hB: hex_code = 7'h03;
      4'hC: hex_code = 7'h46;
      4'hD: hex_code = 7'h21;
      4'hE: hex_code = 7'h06;
      default: hex_code = 7'h0E;
    endcase
  endfunction

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    slot_end    = (state == SHOW) ? (cnt == CW'(DIGIT_CYCLES - 1))
                                  : (cnt == CW'(BLANK_CYCLES - 1));
    boundary    = (state == BLANK) && (idx == 2'd3) && slot_end;
    accept      = bus.load && bus.ready;
    nxt_state   = state;
    nxt_idx     = idx;
    nxt_cnt     = cnt + CW'(1);
    if (slot_end) begin
      nxt_cnt = '0;
      if (state == SHOW) begin
        nxt_state = BLANK;
      end else begin
        nxt_state = SHOW;
        nxt_idx   = idx + 2'd1;
      end
    end
    nxt_disp    = (boundary && pending) ? shadow : displayed;
    nxt_pending = accept ? 1'b1 : (boundary ? 1'b0 : pending);

    nibble = nxt_disp[{nxt_idx, 2'b00} +: 4];
    case (nxt_idx)
      2'd1:    lz_blank = (nxt_disp[15:4] == 12'h000);
      2'd2:    lz_blank = (nxt_disp[15:8] == 8'h00);
      2'd3:    lz_blank = (nxt_disp[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    visible  = (nxt_state == SHOW) && bus.disp_en && !(bus.lzb && lz_blank);
    nxt_an   = visible ? ~(4'b0001 << nxt_idx) : 4'hF;
    nxt_sseg = visible ? hex_code(nibble) : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BLANK;
      idx            <= 2'd3;
      cnt            <= '0;
      displayed      <= 16'h0000;
      shadow         <= 16'h0000;
      pending        <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.ready      <= 1'b1;
      bus.frame_done <= 1'b0;
      bus.an         <= 4'hF;
      bus.sseg       <= 7'h7F;
    end else begin
      state          <= nxt_state;
      idx            <= nxt_idx;
      cnt            <= nxt_cnt;
      displayed      <= nxt_disp;
      pending        <= nxt_pending;
      if (accept) shadow <= bus.data_in;
      if (bus.load && !bus.ready) bus.overrun <= 1'b1;
      bus.ready      <= !nxt_pending;
      bus.frame_done <= boundary;
      bus.an         <= nxt_an;
      bus.sseg       <= nxt_sseg;
    end
  end

endmodule
